// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: FSM encoding,
// datapath width and the default bus timeout.
package mem_access_ctrl_pkg;

    localparam int WORD_W          = 32;
    localparam int TAG_W           = WORD_W - 2;
    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_line_buffer.sv
// One-entry read buffer: word tag compare, fill on load completion and
// write-through update on a store hit (stores never allocate).
module mem_line_buffer
    import mem_access_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              hit,
    output logic [WORD_W-1:0] hit_data,
    input  logic              fill_en,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [WORD_W-1:0] fill_data,
    input  logic              wr_en,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [WORD_W-1:0] wr_data
);

    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] data;

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments keep every flop update order-independent.
        if (reset) begin
            valid <= 1'b0;
        end else if (fill_en) begin
            valid <= 1'b1;
        end
    end

    // NOTE: tag/data are storage qualified by valid, so they carry no reset.
    always_ff @(posedge clock) begin
        if (fill_en) begin
            tag  <= fill_tag;
            data <= fill_data;
        end else if (wr_en && valid && (wr_tag == tag)) begin
            data <= wr_data;
        end
    end

    assign hit      = valid && (tag == lookup_tag);
    assign hit_data = data;

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: serves load hits from a one-entry buffer,
// otherwise runs one bus transaction with timeout, stalling the pipeline.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              stall,
    output logic              err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [WORD_W-1:0] bus_addr,
    output logic [WORD_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [WORD_W-1:0] bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [WORD_W-1:0] rdata_q;
    logic              done_err_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic [WORD_W-1:0] bus_addr_q;
    logic [WORD_W-1:0] bus_wdata_q;

    logic              buf_hit;
    logic [WORD_W-1:0] buf_data;
    logic              misaligned;
    logic              read_only;
    logic              start;
    logic              ack_in_req;

    mem_line_buffer u_line_buffer (
        .clock      (clock),
        .reset      (reset),
        .lookup_tag (addr[WORD_W-1:2]),
        .hit        (buf_hit),
        .hit_data   (buf_data),
        .fill_en    (ack_in_req && !bus_we_q),
        .fill_tag   (bus_addr_q[WORD_W-1:2]),
        .fill_data  (bus_rdata),
        .wr_en      (ack_in_req && bus_we_q),
        .wr_tag     (bus_addr_q[WORD_W-1:2]),
        .wr_data    (bus_wdata_q)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        rdata      = '0;
        misaligned = (mem_read || mem_write) && (addr[1:0] != 2'b00);
        read_only  = mem_read && !mem_write;
        ack_in_req = (state == REQ) && bus_ack;
        start      = (state == IDLE) && !misaligned
                     && (mem_write || (read_only && !buf_hit));
        stall      = start || (state == REQ);
        err        = ((state == IDLE) && misaligned) || ((state == DONE) && done_err_q);
        if (state == DONE) begin
            rdata = rdata_q;
        end else if ((state == IDLE) && read_only && buf_hit && !misaligned) begin
            rdata = buf_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            rdata_q     <= '0;
            done_err_q  <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= REQ;
                        wait_cnt    <= '0;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mem_write;
                        bus_addr_q  <= {addr[WORD_W-1:2], 2'b00};
                        bus_wdata_q <= wdata;
                        // A simultaneous read+write proceeds as a write but is flagged.
                        done_err_q  <= mem_read && mem_write;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        state     <= DONE;
                        bus_req_q <= 1'b0;
                        rdata_q   <= bus_we_q ? '0 : bus_rdata;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state      <= DONE;
                        bus_req_q  <= 1'b0;
                        rdata_q    <= '0;
                        done_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    rdata_q    <= '0;
                    done_err_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: misses, hits, stores, misalignment,
// timeout, read/write conflict and reset in the middle of a bus access.
module tb_mem_access_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata, rdata;
    logic        stall, err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int passed = 0;
    int total  = 0;

    mem_access_ctrl #(.TIMEOUT(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .err       (err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Drives one access until the first cycle with stall low (the DONE cycle,
    // or the IDLE cycle itself for hits/errors), acking in REQ cycle ack_at (0 = never).
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input int ack_at, input logic [31:0] ack_data,
                              output int stall_n, output int req_n,
                              output logic [31:0] out_rdata, output logic out_err,
                              output logic we_seen, output logic [31:0] addr_seen,
                              output logic [31:0] wdata_seen);
        stall_n = 0; req_n = 0; out_rdata = 'x; out_err = 'x;
        we_seen = 'x; addr_seen = 'x; wdata_seen = 'x;
        mem_read = rd; mem_write = wr; addr = a; wdata = wd;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus_req) begin
                req_n++;
                we_seen = bus_we; addr_seen = bus_addr; wdata_seen = bus_wdata;
                bus_ack = (req_n == ack_at);
                bus_rdata = ack_data;
            end
            if (!stall) begin
                out_rdata = rdata;
                out_err = err;
                break;
            end
            stall_n++;
            tick();
            bus_ack = 1'b0;
        end
        mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        total++; if (rdata !== 32'h0)   $display("FAIL reset_rdata: got %h want 0", rdata); else passed++;
        total++; if (stall !== 1'b0)    $display("FAIL reset_stall: got %b want 0", stall); else passed++;
        total++; if (err !== 1'b0)      $display("FAIL reset_err: got %b want 0", err); else passed++;
        total++; if (bus_req !== 1'b0)  $display("FAIL reset_bus_req: got %b want 0", bus_req); else passed++;
        total++; if (bus_we !== 1'b0)   $display("FAIL reset_bus_we: got %b want 0", bus_we); else passed++;
        total++; if (bus_addr !== 32'h0)  $display("FAIL reset_bus_addr: got %h want 0", bus_addr); else passed++;
        total++; if (bus_wdata !== 32'h0) $display("FAIL reset_bus_wdata: got %h want 0", bus_wdata); else passed++;
        tick();
    endtask

    task automatic test_load_miss();
        int s, r; logic [31:0] rd, ad, wd; logic e, we;
        run_access(1'b1, 1'b0, 32'h40, 32'h0, 3, 32'hDEADBEEF, s, r, rd, e, we, ad, wd);
        total++; if (s !== 4) $display("FAIL miss_stall_cycles: got %0d want 4", s); else passed++;
        total++; if (r !== 3) $display("FAIL miss_req_cycles: got %0d want 3", r); else passed++;
        total++; if (we !== 1'b0) $display("FAIL miss_bus_we: got %b want 0", we); else passed++;
        total++; if (ad !== 32'h40) $display("FAIL miss_bus_addr: got %h want 40", ad); else passed++;
        total++; if (rd !== 32'hDEADBEEF) $display("FAIL miss_done_rdata: got %h want deadbeef", rd); else passed++;
        total++; if (e !== 1'b0) $display("FAIL miss_done_err: got %b want 0", e); else passed++;
    endtask

    task automatic test_load_hit(input logic [31:0] a, input logic [31:0] exp, input string tag);
        int s, r; logic [31:0] rd, ad, wd; logic e, we;
        run_access(1'b1, 1'b0, a, 32'h0, 1, 32'hFFFF_FFFF, s, r, rd, e, we, ad, wd);
        total++; if (s !== 0) $display("FAIL %s_hit_stall: got %0d want 0", tag, s); else passed++;
        total++; if (r !== 0) $display("FAIL %s_hit_bus_req: got %0d want 0", tag, r); else passed++;
        total++; if (rd !== exp) $display("FAIL %s_hit_rdata: got %h want %h", tag, rd, exp); else passed++;
        #1;
        total++; if (bus_req !== 1'b0) $display("FAIL %s_hit_bus_idle: got %b want 0", tag, bus_req); else passed++;
    endtask

    task automatic test_store();
        int s, r; logic [31:0] rd, ad, wd; logic e, we;
        run_access(1'b0, 1'b1, 32'h40, 32'h12345678, 2, 32'h0, s, r, rd, e, we, ad, wd);
        total++; if (s !== 3) $display("FAIL store_stall_cycles: got %0d want 3", s); else passed++;
        total++; if (we !== 1'b1) $display("FAIL store_bus_we: got %b want 1", we); else passed++;
        total++; if (ad !== 32'h40) $display("FAIL store_bus_addr: got %h want 40", ad); else passed++;
        total++; if (wd !== 32'h12345678) $display("FAIL store_bus_wdata: got %h want 12345678", wd); else passed++;
        total++; if (e !== 1'b0) $display("FAIL store_done_err: got %b want 0", e); else passed++;
        test_load_hit(32'h40, 32'h12345678, "after_store");
    endtask

    task automatic test_misaligned();
        int s, r; logic [31:0] rd, ad, wd; logic e, we;
        run_access(1'b1, 1'b0, 32'h42, 32'h0, 1, 32'h0, s, r, rd, e, we, ad, wd);
        total++; if (s !== 0) $display("FAIL misalign_rd_stall: got %0d want 0", s); else passed++;
        total++; if (r !== 0) $display("FAIL misalign_rd_bus_req: got %0d want 0", r); else passed++;
        total++; if (e !== 1'b1) $display("FAIL misalign_rd_err: got %b want 1", e); else passed++;
        total++; if (rd !== 32'h0) $display("FAIL misalign_rd_rdata: got %h want 0", rd); else passed++;
        #1;
        total++; if (err !== 1'b0) $display("FAIL misalign_err_pulse: got %b want 0", err); else passed++;
        run_access(1'b0, 1'b1, 32'h41, 32'hAAAA5555, 1, 32'h0, s, r, rd, e, we, ad, wd);
        total++; if (e !== 1'b1 || s !== 0 || r !== 0)
            $display("FAIL misalign_wr: got err=%b stall=%0d req=%0d want 1/0/0", e, s, r); else passed++;
    endtask

    task automatic test_timeout();
        int s, r; logic [31:0] rd, ad, wd; logic e, we;
        run_access(1'b1, 1'b0, 32'h80, 32'h0, 0, 32'h0, s, r, rd, e, we, ad, wd);
        total++; if (r !== 16) $display("FAIL timeout_req_cycles: got %0d want 16", r); else passed++;
        total++; if (s !== 17) $display("FAIL timeout_stall_cycles: got %0d want 17", s); else passed++;
        total++; if (e !== 1'b1) $display("FAIL timeout_err: got %b want 1", e); else passed++;
        total++; if (rd !== 32'h0) $display("FAIL timeout_rdata: got %h want 0", rd); else passed++;
        test_load_hit(32'h40, 32'h12345678, "after_timeout");
    endtask

    task automatic test_ack_in_idle();
        bus_ack = 1'b1; bus_rdata = 32'h1;
        tick();
        #1;
        total++; if (bus_req !== 1'b0 || stall !== 1'b0 || err !== 1'b0)
            $display("FAIL idle_ack_ignored: got req=%b stall=%b err=%b want 0/0/0", bus_req, stall, err); else passed++;
        bus_ack = 1'b0;
        tick();
    endtask

    task automatic test_conflict();
        int s, r; logic [31:0] rd, ad, wd; logic e, we;
        run_access(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 1, 32'h0, s, r, rd, e, we, ad, wd);
        total++; if (we !== 1'b1) $display("FAIL conflict_bus_we: got %b want 1", we); else passed++;
        total++; if (s !== 2) $display("FAIL conflict_stall_cycles: got %0d want 2", s); else passed++;
        total++; if (e !== 1'b1) $display("FAIL conflict_done_err: got %b want 1", e); else passed++;
        test_load_hit(32'h40, 32'hCAFEF00D, "after_conflict");
    endtask

    task automatic test_no_allocate();
        int s, r; logic [31:0] rd, ad, wd; logic e, we;
        run_access(1'b0, 1'b1, 32'h100, 32'h77777777, 1, 32'h0, s, r, rd, e, we, ad, wd);
        total++; if (ad !== 32'h100) $display("FAIL noalloc_bus_addr: got %h want 100", ad); else passed++;
        test_load_hit(32'h40, 32'hCAFEF00D, "after_other_store");
        run_access(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'h00000055, s, r, rd, e, we, ad, wd);
        total++; if (s !== 2) $display("FAIL noalloc_load_miss: got %0d want 2", s); else passed++;
        total++; if (rd !== 32'h55) $display("FAIL noalloc_load_rdata: got %h want 55", rd); else passed++;
    endtask

    task automatic test_reset_mid_req();
        int s, r; logic [31:0] rd, ad, wd; logic e, we;
        mem_read = 1'b1; addr = 32'h200;
        tick();
        tick();
        #1;
        total++; if (bus_req !== 1'b1) $display("FAIL midreq_bus_req: got %b want 1", bus_req); else passed++;
        reset = 1'b1; mem_read = 1'b0;
        tick();
        reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h99999999;
        #1;
        total++; if (rdata !== 32'h0 || stall !== 1'b0 || err !== 1'b0 || bus_req !== 1'b0)
            $display("FAIL midreq_outputs: got rdata=%h stall=%b err=%b req=%b want 0", rdata, stall, err, bus_req); else passed++;
        total++; if (bus_we !== 1'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0)
            $display("FAIL midreq_bus_fields: got we=%b addr=%h wdata=%h want 0", bus_we, bus_addr, bus_wdata); else passed++;
        tick();
        bus_ack = 1'b0;
        #1;
        total++; if (bus_req !== 1'b0 || stall !== 1'b0)
            $display("FAIL midreq_late_ack: got req=%b stall=%b want 0/0", bus_req, stall); else passed++;
        run_access(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'h0BADF00D, s, r, rd, e, we, ad, wd);
        total++; if (s !== 2) $display("FAIL midreq_buffer_invalid: got %0d want 2", s); else passed++;
        total++; if (rd !== 32'h0BADF00D) $display("FAIL midreq_reload_rdata: got %h want 0badf00d", rd); else passed++;
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_load_hit(32'h40, 32'hDEADBEEF, "repeat");
        test_store();
        test_misaligned();
        test_timeout();
        test_ack_in_idle();
        test_conflict();
        test_no_allocate();
        test_reset_mid_req();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, 16, max cycles to wait for bus_ack before aborting an access.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 mem_read  in  1  load request from the decoder (MemRead).
REQ-005 mem_write  in  1  store request from the decoder (MemWrite).
REQ-006 addr  in  32  byte address from the ALU (ALU_Result).
REQ-007 wdata  in  32  store data (Read_data2).
REQ-008 rdata  out  32  load data to the write-back mux.
REQ-009 stall  out  1  high: PC unit and register file writes hold this cycle.
REQ-010 err  out  1  one-cycle pulse: misaligned, conflicting or timed-out access.
REQ-011 bus_req  out  1  backing-memory request, held until bus_ack or timeout.
REQ-012 bus_we  out  1  bus write enable, valid while bus_req high.
REQ-013 bus_addr  out  32  word-aligned bus address ({addr[31:2],2'b00}), stable while bus_req high.
REQ-014 bus_wdata  out  32  bus store data, stable while bus_req high.
REQ-015 bus_ack  in  1  backing memory completes the access this cycle.
REQ-016 bus_rdata  in  32  load data, valid when bus_ack high.

Function
REQ-017 FSM states IDLE, REQ, DONE; reset state IDLE.
REQ-018 One-entry read buffer: valid bit, 30-bit word tag, 32-bit data.
REQ-019 IDLE, mem_read, buffer hit (valid, tag==addr[31:2]): rdata=buffer data combinationally, stall=0, no bus access, stay IDLE.
REQ-020 IDLE, (mem_read and miss) or mem_write, aligned: stall=1 combinationally, latch addr/wdata/op, go REQ.
REQ-021 REQ: bus_req=1, stall=1, bus_we=latched op; wait-cycle counter increments each cycle.
REQ-022 REQ and bus_ack: read captures bus_rdata into rdata register and fills buffer; write updates buffer data if tag matches (write-through, no allocate); go DONE.
REQ-023 REQ and counter reaching TIMEOUT without ack: drop bus_req, rdata=0, err=1 in DONE, buffer unchanged.
REQ-024 DONE: stall=0, rdata=registered value, bus_req=0; mem_read/mem_write ignored; next state IDLE.
REQ-025 Bus latency of N cycles (ack in Nth REQ cycle) gives stall high for N+1 cycles including the IDLE cycle.
REQ-026 addr[1:0]!=0 with mem_read or mem_write in IDLE: no bus access, stall=0, rdata=0, err=1 same cycle.
REQ-027 mem_read and mem_write both high in IDLE: treated as write, err=1 in the DONE cycle.
REQ-028 bus_ack while not in REQ is ignored.
REQ-029 rdata=0 in IDLE when no buffer hit.

Reset
REQ-030 Reset has priority over every transition, including mid-REQ; state IDLE, buffer invalid, counter 0.
REQ-031 After reset: rdata=0, stall=0, err=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0.
REQ-032 An access aborted by reset is not retried; a late bus_ack is ignored per REQ-028.

Structure
REQ-033 Shared package holds the FSM state encoding, the word width (32) and the default TIMEOUT.
REQ-034 The read buffer is one sub-module, mem_line_buffer (tag compare, fill, write-update).

Verification
REQ-035 Load miss 0x40, bus ack after 3 cycles with 0xDEADBEEF -> stall high 4 cycles, rdata=0xDEADBEEF in DONE, one bus_req burst with bus_we=0.
REQ-036 Repeat load 0x40 -> stall=0, rdata=0xDEADBEEF same cycle, bus_req stays 0.
REQ-037 Store 0x12345678 to 0x40, then load 0x40 -> bus write seen with bus_addr=0x40; load hits with rdata=0x12345678.
REQ-038 Load 0x42 -> err pulse, stall=0, rdata=0, no bus_req.
REQ-039 Load 0x80, bus_ack never asserted, TIMEOUT=16 -> bus_req drops after 16 cycles, DONE with err=1, rdata=0, buffer still tags 0x40.
REQ-040 reset asserted in 2nd REQ cycle, bus_ack next cycle -> outputs at reset values, state IDLE, ack ignored, buffer invalid (next load 0x40 misses).
